instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch.sv | 134 +++++++++++++
 tb/tb_instruction_fetch.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC input, instruction-memory read port and decoder handoff.
// The master side is the fetch unit; the slave side is memory, PC stage and decoder.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] pc_pos;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic              init_flag;
  logic              fetch_err;

  modport master (
    input  pc_pos, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr, instr_addr, instr_valid, init_flag, fetch_err
  );

  modport slave (
    output pc_pos, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr, instr_addr, instr_valid, init_flag, fetch_err
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: requests the word at pc_pos, drops returns for a stale PC,
// holds the fetched word for the decoder and latches a sticky error on memory timeout.
module instruction_fetch #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                 clock,
  input logic                 reset_n,
  instruction_fetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              init_flag_q, init_flag_d;
  logic              fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_addr_q  <= '0;
      instr_valid_q <= 1'b0;
      init_flag_q   <= 1'b0;
      fetch_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_addr_q  <= instr_addr_d;
      instr_valid_q <= instr_valid_d;
      init_flag_q   <= init_flag_d;
      fetch_err_q   <= fetch_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_addr_d  = instr_addr_q;
    instr_valid_d = instr_valid_q;
    init_flag_d   = init_flag_q;
    fetch_err_d   = fetch_err_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      IDLE: begin
        mem_addr_d = bus.pc_pos;
        mem_req_d  = 1'b1;
        cnt_d      = '0;
        state_d    = ISSUE;
      end

      ISSUE: begin
        if (bus.mem_ack) begin
          if (bus.pc_pos == mem_addr_q) begin
            instr_d       = bus.mem_rdata;
            instr_addr_d  = mem_addr_q;
            instr_valid_d = 1'b1;
            mem_req_d     = 1'b0;
            init_flag_d   = 1'b1;
            state_d       = HOLD;
          end else begin
            // PC moved while the read was in flight: drop the word and refetch
            mem_addr_d = bus.pc_pos;
            cnt_d      = '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d       = CNT_MAX;
          fetch_err_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        // Consumed, or flushed because the PC no longer points at the held word
        if (bus.instr_ready || (bus.pc_pos != instr_addr_q)) begin
          instr_valid_d = 1'b0;
          mem_addr_d    = bus.pc_pos;
          mem_req_d     = 1'b1;
          cnt_d         = '0;
          state_d       = ISSUE;
        end
      end

      ERROR: begin
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = instr_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.init_flag   = init_flag_q;
  assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory/PC-stage model drives the bus, a scoreboard
// queue of expected deliveries is checked by an independent monitor.
module tb_instruction_fetch;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instruction_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] req_log[$];
  int                total = 0;
  int                bad = 0;

  // Memory model: 0 random latency 1..4, 1 fixed latency, 2 never answers, 3 spurious ack
  int mem_mode = 1;
  int lat_fix  = 1;
  bit busy     = 1'b0;
  bit ack_last = 1'b0;
  int wait_n   = 0;
  bit mon_prev = 1'b0;

  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return 32'hDEADBEEF ^ {a, a[7:0], a[15:8]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs at a negedge; every ack whose address equals the PC the DUT will sample is a delivery
  task automatic mem_tick();
    exp_t e;
    if (!reset_n) begin
      busy = 1'b0;
      ack_last = 1'b0;
      bus.mem_ack = 1'b0;
      return;
    end
    if (ack_last) begin
      bus.mem_ack = 1'b0;
      busy = 1'b0;
      ack_last = 1'b0;
    end
    if (mem_mode == 3) begin
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h0BAD0BAD;
      ack_last = 1'b1;
      return;
    end
    if (bus.mem_req && !busy) begin
      busy = 1'b1;
      req_log.push_back(bus.mem_addr);
      wait_n = (mem_mode == 1) ? lat_fix - 1 : int'($urandom_range(3, 0));
    end
    if (busy && mem_mode != 2) begin
      if (wait_n == 0) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = mem_fn(bus.mem_addr);
        ack_last = 1'b1;
        if (bus.pc_pos == bus.mem_addr) begin
          e.addr = bus.mem_addr;
          e.data = mem_fn(bus.mem_addr);
          exp_q.push_back(e);
        end
      end else begin
        wait_n--;
      end
    end
  endtask

  task automatic step();
    mem_tick();
    @(negedge clock);
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (!bus.instr_valid && n < max) begin
      step();
      n++;
    end
    check(name, 64'(bus.instr_valid), 64'(1));
  endtask

  task automatic settle();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("sb_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] pc);
    settle();
    reset_n = 1'b0;
    bus.pc_pos = pc;
    step();
    step();
    reset_n = 1'b1;
    req_log.delete();
  endtask

  // Monitor: each new presentation of instr_valid consumes one expected delivery
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.instr_valid && !mon_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got addr %0h data %0h, expected no delivery",
                   bus.instr_addr, bus.instr);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", 64'(bus.instr_addr), 64'(e.addr));
          check("sb_data", 64'(bus.instr), 64'(e.data));
          check("sb_init", 64'(bus.init_flag), 64'(1));
        end
      end
      mon_prev = bus.instr_valid;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int got;
    int last_t;
    logic [ADDR_W-1:0] addrs[$];

    bus.pc_pos = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.instr_ready = 1'b0;
    #12;
    check("rst_mem_req",    64'(bus.mem_req), 64'(0));
    check("rst_mem_addr",   64'(bus.mem_addr), 64'(0));
    check("rst_instr",      64'(bus.instr), 64'(0));
    check("rst_instr_addr", 64'(bus.instr_addr), 64'(0));
    check("rst_valid",      64'(bus.instr_valid), 64'(0));
    check("rst_init",       64'(bus.init_flag), 64'(0));
    check("rst_err",        64'(bus.fetch_err), 64'(0));

    // Basic fetch with a two-cycle memory
    @(negedge clock);
    mem_mode = 1;
    lat_fix = 2;
    reset_n = 1'b1;
    step();
    check("basic_req", 64'(bus.mem_req), 64'(1));
    check("basic_req_addr", 64'(bus.mem_addr), 64'(0));
    wait_valid("basic_wait", 10);
    check("basic_instr", 64'(bus.instr), 64'(32'hDEADBEEF));
    check("basic_addr", 64'(bus.instr_addr), 64'(0));
    check("basic_init", 64'(bus.init_flag), 64'(1));

    // Stream with the decoder always ready and a one-cycle memory
    lat_fix = 1;
    do_reset(16'h0000);
    bus.instr_ready = 1'b1;
    got = 0;
    last_t = 0;
    n = 0;
    while (got < 4 && n < 100) begin
      if (bus.instr_valid) begin
        addrs.push_back(bus.instr_addr);
        if (got > 0) check("stream_gap", 64'(n - last_t), 64'(2));
        last_t = n;
        got++;
        bus.pc_pos = bus.instr_addr + 16'd1;
      end
      step();
      n++;
    end
    check("stream_count", 64'(got), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check("stream_addr", 64'((addrs.size() > i) ? addrs[i] : 16'hFFFF), 64'(i));
      check("stream_req", 64'((req_log.size() > i) ? req_log[i] : 16'hFFFF), 64'(i));
    end

    // Stale return after a jump
    lat_fix = 3;
    do_reset(16'h0005);
    step();
    bus.pc_pos = 16'h0040;
    wait_valid("stale_wait", 20);
    check("stale_addr", 64'(bus.instr_addr), 64'(16'h0040));
    check("stale_data", 64'(bus.instr), 64'(mem_fn(16'h0040)));
    check("stale_req_cnt", 64'(req_log.size()), 64'(2));
    check("stale_req1", 64'((req_log.size() > 1) ? req_log[1] : 16'hFFFF), 64'(16'h0040));

    // Hold, then flush on a PC change
    lat_fix = 1;
    do_reset(16'h0010);
    wait_valid("flush_wait", 10);
    step();
    step();
    check("hold_valid", 64'(bus.instr_valid), 64'(1));
    check("hold_addr", 64'(bus.instr_addr), 64'(16'h0010));
    bus.pc_pos = 16'h0020;
    step();
    check("flush_valid", 64'(bus.instr_valid), 64'(0));
    check("flush_req", 64'(bus.mem_req), 64'(1));
    check("flush_maddr", 64'(bus.mem_addr), 64'(16'h0020));
    wait_valid("flush_refetch", 10);
    check("flush_new_addr", 64'(bus.instr_addr), 64'(16'h0020));

    // Memory timeout and terminal error
    mem_mode = 2;
    do_reset(16'h0007);
    step();
    check("to_req", 64'(bus.mem_req), 64'(1));
    n = 0;
    while (!bus.fetch_err && n < 200) begin
      step();
      n++;
    end
    check("to_cycles", 64'(n), 64'(TIMEOUT));
    check("to_err", 64'(bus.fetch_err), 64'(1));
    check("to_req_low", 64'(bus.mem_req), 64'(0));
    mem_mode = 3;
    step();
    mem_mode = 2;
    step();
    step();
    check("err_sticky", 64'(bus.fetch_err), 64'(1));
    check("err_req", 64'(bus.mem_req), 64'(0));
    check("err_valid", 64'(bus.instr_valid), 64'(0));
    check("err_init", 64'(bus.init_flag), 64'(0));

    // Asynchronous reset with a request outstanding
    mem_mode = 1;
    lat_fix = 1;
    do_reset(16'h0033);
    wait_valid("ar_wait", 10);
    mem_mode = 2;
    bus.pc_pos = 16'h0034;
    step();
    step();
    check("ar_pre_req", 64'(bus.mem_req), 64'(1));
    check("ar_pre_init", 64'(bus.init_flag), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("ar_mem_req", 64'(bus.mem_req), 64'(0));
    check("ar_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("ar_instr", 64'(bus.instr), 64'(0));
    check("ar_instr_addr", 64'(bus.instr_addr), 64'(0));
    check("ar_valid", 64'(bus.instr_valid), 64'(0));
    check("ar_init", 64'(bus.init_flag), 64'(0));
    check("ar_err", 64'(bus.fetch_err), 64'(0));
    @(negedge clock);
    step();
    mem_mode = 3;
    reset_n = 1'b1;
    step();
    mem_mode = 1;
    lat_fix = 2;
    wait_valid("ar_refetch", 10);
    check("ar_new_addr", 64'(bus.instr_addr), 64'(16'h0034));
    check("ar_new_data", 64'(bus.instr), 64'(mem_fn(16'h0034)));

    // Random decoder stalls, jumps and memory latency
    mem_mode = 0;
    do_reset(16'h0100);
    for (int c = 0; c < 600; c++) begin
      bit rdy;
      rdy = 1'($urandom_range(1, 0));
      bus.instr_ready = rdy;
      if (bus.instr_valid && rdy)
        bus.pc_pos = ($urandom_range(9, 0) == 0) ? 16'h0100 + 16'($urandom_range(15, 0))
                                                  : bus.instr_addr + 16'd1;
      else if ($urandom_range(9, 0) == 0)
        bus.pc_pos = 16'h0100 + 16'($urandom_range(15, 0));
      step();
    end
    settle();
    check("rand_no_err", 64'(bus.fetch_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
